// File: rtl/prio_encoder_irq.sv
// prio_encoder_irq: registered N-to-log2(N) priority encoder, sticky pending, mask, grant/ack.
// Optional rotating priority when PRIO_ENC_ROUND_ROBIN_EN is defined.
module prio_encoder_irq #(
    parameter int N    = 8,
    parameter int EDGE = 0,
    localparam int W   = (N == 2) ? 1 : $clog2(N)
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         ena,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         ack,
    output logic [W-1:0] n,
    output logic         g,
    output logic [N-1:0] pend
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] req_d_q;
    logic [N-1:0] new_req, clr, elig;
    logic [W-1:0] n_q, n_d, sel;
    logic         g_q, g_d;
    logic         found, accept;

    assign new_req = (EDGE != 0) ? (req & ~req_d_q) : req;
    assign elig    = pend_q & mask;
    assign accept  = (state_q == GRANT) && ack && ena;

    // A new request on the bit being cleared wins: OR after the clear.
    always_comb begin
        clr = '0;
        if (accept) clr[n_q] = 1'b1;
        pend_d = (pend_q & ~clr) | new_req;
    end

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;
    int           rr_idx;

    // Walk from lowest to highest rank so the highest-ranked hit is kept.
    always_comb begin
        sel    = '0;
        found  = 1'b0;
        rr_idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            rr_idx = int'(ptr_q) - k;
            if (rr_idx < 0) rr_idx = rr_idx + N;
            if (elig[W'(rr_idx)]) begin
                sel   = W'(rr_idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) ptr_d = (n_q == '0) ? W'(N - 1) : n_q - 1'b1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) ptr_q <= W'(N - 1);
        else       ptr_q <= ptr_d;
    end
`else
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                sel   = W'(i);
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        n_d     = n_q;
        unique case (state_q)
            IDLE: begin
                if (ena && found) begin
                    state_d = GRANT;
                    g_d     = 1'b1;
                    n_d     = sel;
                end else begin
                    g_d = 1'b0;
                end
            end
            GRANT: begin
                if (!ena || ack) begin
                    state_d = IDLE;
                    g_d     = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            pend_q  <= '0;
            req_d_q <= '0;
            n_q     <= '0;
            g_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            req_d_q <= req;
            n_q     <= n_d;
            g_q     <= g_d;
        end
    end

    assign n    = n_q;
    assign g    = g_q;
    assign pend = pend_q;

endmodule

// File: tb/tb_prio_encoder_irq.sv
// Testbench for prio_encoder_irq: vector table through a scoreboard queue plus
// hand-written sequences for edge capture, async reset and rotating priority.
module tb_prio_encoder_irq;

    localparam int N = 8;
    localparam int W = 3;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] mask;
        logic         ena;
        logic         ack;
        logic [N-1:0] pend;
        logic         g;
        logic [W-1:0] n;
    } vec_t;

    logic         clk  = 1'b0;
    logic         clrn = 1'b0;
    logic         ena  = 1'b0;
    logic         ack  = 1'b0;
    logic         ack1 = 1'b0;
    logic [N-1:0] req  = '0;
    logic [N-1:0] req1 = '0;
    logic [N-1:0] mask = '0;
    logic [W-1:0] n, n1;
    logic         g, g1;
    logic [N-1:0] pend, pend1;

    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];
    vec_t sb[$];
    int   expn[$];

    always #5 clk = ~clk;

    prio_encoder_irq #(.N(N), .EDGE(0)) dut0 (
        .clk(clk), .clrn(clrn), .ena(ena), .req(req), .mask(mask),
        .ack(ack), .n(n), .g(g), .pend(pend)
    );

    prio_encoder_irq #(.N(N), .EDGE(1)) dut1 (
        .clk(clk), .clrn(clrn), .ena(ena), .req(req1), .mask(mask),
        .ack(ack1), .n(n1), .g(g1), .pend(pend1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] r, input logic [7:0] m, input logic e,
                       input logic a, input logic [7:0] p, input logic gg,
                       input logic [2:0] nn);
        vec_t v;
        v.req = r; v.mask = m; v.ena = e; v.ack = a;
        v.pend = p; v.g = gg; v.n = nn;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t e;
        int   grants;
        logic acc;

        tick();
        chk("rst.pend", 32'(pend), 32'h0);
        chk("rst.g", 32'(g), 32'h0);
        chk("rst.n", 32'(n), 32'h0);
        clrn = 1'b1;

`ifndef PRIO_ENC_ROUND_ROBIN_EN
        //   req    mask  ena ack  pend  g  n
        add(8'h24, 8'hFF, 1, 0, 8'h24, 0, 0);
        add(8'h00, 8'hFF, 1, 0, 8'h24, 1, 5);
        add(8'h00, 8'hFF, 1, 1, 8'h04, 0, 5);
        add(8'h00, 8'hFF, 1, 0, 8'h04, 1, 2);
        add(8'h00, 8'hFF, 1, 1, 8'h00, 0, 2);
        add(8'h00, 8'hFF, 1, 0, 8'h00, 0, 2);
        add(8'h00, 8'hFF, 1, 1, 8'h00, 0, 2);
        add(8'h80, 8'h7F, 1, 0, 8'h80, 0, 2);
        add(8'h00, 8'h7F, 1, 0, 8'h80, 0, 2);
        add(8'h00, 8'h7F, 1, 0, 8'h80, 0, 2);
        add(8'h00, 8'hFF, 1, 0, 8'h80, 1, 7);
        add(8'h00, 8'hFF, 1, 1, 8'h00, 0, 7);
        add(8'h08, 8'hFF, 1, 0, 8'h08, 0, 7);
        add(8'h00, 8'hFF, 1, 0, 8'h08, 1, 3);
        add(8'h00, 8'hFF, 0, 1, 8'h08, 0, 3);
        add(8'h00, 8'hFF, 1, 0, 8'h08, 1, 3);
        add(8'h00, 8'h00, 1, 0, 8'h08, 1, 3);
        add(8'h08, 8'hFF, 1, 1, 8'h08, 0, 3);
        add(8'h00, 8'hFF, 1, 0, 8'h08, 1, 3);
        add(8'h00, 8'hFF, 1, 1, 8'h00, 0, 3);
        add(8'h13, 8'hFF, 1, 0, 8'h13, 0, 3);
        add(8'h00, 8'h0F, 1, 0, 8'h13, 1, 1);
        add(8'h80, 8'h0F, 1, 0, 8'h93, 1, 1);
        add(8'h00, 8'h0F, 1, 1, 8'h91, 0, 1);
        add(8'h00, 8'hFF, 1, 0, 8'h91, 1, 7);
        add(8'h00, 8'hFF, 1, 1, 8'h11, 0, 7);
        add(8'h00, 8'hFF, 1, 0, 8'h11, 1, 4);
        add(8'h00, 8'hFF, 1, 1, 8'h01, 0, 4);
        add(8'h00, 8'hFF, 1, 0, 8'h01, 1, 0);
        add(8'h00, 8'hFF, 1, 1, 8'h00, 0, 0);
        add(8'h00, 8'hFF, 1, 0, 8'h00, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            req  = tbl[i].req;
            mask = tbl[i].mask;
            ena  = tbl[i].ena;
            ack  = tbl[i].ack;
            sb.push_back(tbl[i]);
            tick();
            e = sb.pop_front();
            chk($sformatf("v%0d.pend", i), 32'(pend), 32'(e.pend));
            chk($sformatf("v%0d.g", i), 32'(g), 32'(e.g));
            chk($sformatf("v%0d.n", i), 32'(n), 32'(e.n));
        end
`endif
        req  = '0;
        ack  = 1'b0;
        mask = 8'hFF;
        ena  = 1'b1;

        // Rising-edge capture: a held request yields one grant only.
        grants = 0;
        req1   = 8'h01;
        for (int i = 0; i < 10; i++) begin
            acc = g1 & ack1;
            tick();
            if (acc) grants++;
            ack1 = g1;
        end
        chk("edge.grants", 32'(grants), 32'd1);
        chk("edge.pend", 32'(pend1), 32'h0);
        chk("edge.g", 32'(g1), 32'h0);
        req1 = 8'h00;
        tick();
        req1 = 8'h01;
        tick();
        chk("edge.repend", 32'(pend1), 32'h01);
        tick();
        chk("edge.regrant.g", 32'(g1), 32'h1);
        chk("edge.regrant.n", 32'(n1), 32'h0);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        chk("edge.clear", 32'(pend1), 32'h0);

        // Async reset in the middle of a grant.
        req = 8'hFF;
        tick();
        tick();
        chk("pre_rst.g", 32'(g), 32'h1);
        chk("pre_rst.n", 32'(n), 32'h7);
        chk("pre_rst.pend", 32'(pend), 32'hFF);
        #2 clrn = 1'b0;
        #1;
        chk("async.g", 32'(g), 32'h0);
        chk("async.n", 32'(n), 32'h0);
        chk("async.pend", 32'(pend), 32'h0);
        tick();
        clrn = 1'b1;

        // Held requests with every grant acknowledged.
        for (int i = 0; i < 9; i++) begin
`ifdef PRIO_ENC_ROUND_ROBIN_EN
            expn.push_back((7 - i + 8) % 8);
`else
            expn.push_back(7);
`endif
        end
        for (int c = 0; c < 60 && expn.size() > 0; c++) begin
            tick();
            if (g && !ack) begin
                chk($sformatf("seq.n%0d", 9 - expn.size()), 32'(n), 32'(expn.pop_front()));
                ack = 1'b1;
            end else begin
                ack = 1'b0;
            end
        end
        chk("seq.timeout", 32'(expn.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
